// File: rtl/spi_digit_cmd.sv
// Byte-stream command decoder feeding a 4-digit 7-segment display.
// Define SPI_DIGIT_CMD_TIMEOUT_EN to abort stalled multi-byte commands after TIMEOUT_CYCLES.
module spi_digit_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             cs_n,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [1:0]       colon,
  output logic             update,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, WAIT_ONE, WAIT_LO, WAIT_HI} state_t;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_digits, w_digits_nxt;
  logic [1:0]       r_colon, w_colon_nxt;
  logic             r_update, w_update_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_hold, w_hold_nxt;
  logic             r_cs_n_d;
  logic             w_cs_rise;
  logic             w_tmo_hit;
  logic             w_err_inc;

  assign w_cs_rise = cs_n & ~r_cs_n_d;

`ifdef SPI_DIGIT_CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  // Hit on the edge where the counter would reach zero, unless a byte arrives.
  assign w_tmo_hit = (r_state != IDLE) && !rx_valid && (r_tmo == TW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (rx_valid) begin
      r_tmo <= TW'(TIMEOUT_CYCLES);
    end else if (r_state != IDLE && r_tmo != '0) begin
      r_tmo <= r_tmo - 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_colon_nxt  = r_colon;
    w_update_nxt = 1'b0;
    w_idx_nxt    = r_idx;
    w_hold_nxt   = r_hold;
    w_err_inc    = 1'b0;

    if (rx_valid) begin
      case (r_state)
        IDLE: begin
          case (rx_data[7:4])
            4'h0: ;
            4'h1: begin
              w_idx_nxt   = rx_data[1:0];
              w_state_nxt = WAIT_ONE;
            end
            4'h2: w_state_nxt = WAIT_LO;
            4'h3: begin
              w_colon_nxt  = rx_data[1:0];
              w_update_nxt = 1'b1;
            end
            4'h4: begin
              w_digits_nxt = r_digits + 16'd1;
              w_update_nxt = 1'b1;
            end
            4'h5: begin
              w_digits_nxt = '0;
              w_colon_nxt  = '1;
              w_update_nxt = 1'b1;
            end
            default: w_err_inc = 1'b1;
          endcase
        end
        WAIT_ONE: begin
          w_digits_nxt[{r_idx, 2'b00} +: 4] = rx_data[3:0];
          w_update_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end
        WAIT_LO: begin
          w_hold_nxt  = rx_data;
          w_state_nxt = WAIT_HI;
        end
        WAIT_HI: begin
          w_digits_nxt = {rx_data, r_hold};
          w_update_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    // Abort is judged after the byte of this cycle has been applied.
    if (w_state_nxt != IDLE && (w_cs_rise || w_tmo_hit)) begin
      w_state_nxt = IDLE;
      w_hold_nxt  = '0;
      w_err_inc   = 1'b1;
    end

    w_err_nxt = (w_err_inc && r_err != '1) ? r_err + 1'b1 : r_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_digits <= '0;
      r_colon  <= '1;
      r_update <= 1'b0;
      r_err    <= '0;
      r_idx    <= '0;
      r_hold   <= '0;
      r_cs_n_d <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_digits <= w_digits_nxt;
      r_colon  <= w_colon_nxt;
      r_update <= w_update_nxt;
      r_err    <= w_err_nxt;
      r_idx    <= w_idx_nxt;
      r_hold   <= w_hold_nxt;
      r_cs_n_d <= cs_n;
    end
  end

  assign digit0    = r_digits[3:0];
  assign digit1    = r_digits[7:4];
  assign digit2    = r_digits[11:8];
  assign digit3    = r_digits[15:12];
  assign colon     = r_colon;
  assign update    = r_update;
  assign busy      = (r_state != IDLE);
  assign err_count = r_err;

endmodule

// File: doc/spi_digit_cmd.md
# spi_digit_cmd

Byte-stream command decoder between the SPI slave receiver and the 4-digit 7-segment driver. Consumes received bytes (one-cycle valid strobe plus data), parses a small opcode protocol, and maintains the four 4-bit digit registers and 2-bit colon control that feed the display interface. Also counts protocol errors and aborts partial commands on chip-select release.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: clk cycles allowed between bytes of a multi-byte command before abort (timeout build only).
- ERR_W, 8: width of saturating error counter.

Ports:
- clk  in  1  system clock; one clock for the whole block.
- reset  in  1  asynchronous, active-high; clears all state.
- rx_valid  in  1  one-cycle strobe, byte present on rx_data, synchronous to clk.
- rx_data  in  8  received byte.
- cs_n  in  1  SPI chip select, active low, already synchronised to clk.
- digit0..digit3  out  4 each  display digits, digit0 = LSD.
- colon  out  2  00 colon, 01 decimal point, 11 none.
- update  out  1  one-cycle pulse when any digit or colon register changes.
- busy  out  1  high while a multi-byte command is incomplete.
- err_count  out  ERR_W  saturating protocol error count.

## Operation
- Opcode = rx_data[7:4] of a byte received in IDLE:
  - 0x0: NOP, no state change.
  - 0x1: write single digit; index = rx_data[1:0]; next byte's low nibble becomes that digit. -> WAIT_ONE.
  - 0x2: write all; next byte = {digit1,digit0}, then {digit3,digit2}. -> WAIT_LO -> WAIT_HI.
  - 0x3: colon <= rx_data[1:0], immediate.
  - 0x4: increment {digit3..digit0} as a 16-bit hex value, FFFF wraps to 0000.
  - 0x5: clear: digits <= 0, colon <= 11.
  - 0x6-0xF: illegal; err_count += 1, stay IDLE.
- States: IDLE, WAIT_ONE, WAIT_LO, WAIT_HI. Data bytes in WAIT_* are taken as data regardless of value.
- WAIT_LO: bytes latched into a holding register; digit outputs change only on the WAIT_HI byte (all four update atomically).
- Abort (return IDLE, holding register discarded, err_count += 1): cs_n rising edge while in WAIT_*, or timeout.
- rx_valid and cs_n rising in same cycle: byte processed first; abort applies only if the command is still incomplete after that byte.
- err_count saturates at all-ones; never wraps.
- busy = state != IDLE.
- reset mid-command: immediate return to IDLE, all outputs to reset values.

## Timing
- Reset values: digit0..3 = 0, colon = 11, update = 0, busy = 0, err_count = 0, state IDLE.
- Outputs registered; a completing byte at rx_valid edge N gives new digit/colon values and update = 1 after edge N (visible cycle N+1); update lasts exactly one cycle.
- update fires for opcodes 0x1 (on data byte), 0x2 (on second data byte), 0x3, 0x4, 0x5, even if values unchanged; never for NOP, illegal or abort.
- Back-to-back rx_valid on consecutive cycles fully supported; no back-pressure.
- busy rises the cycle after the opcode byte, falls the cycle after the final data byte or abort.

## Configuration
- SPI_DIGIT_CMD_TIMEOUT_EN defined: a counter reloads to TIMEOUT_CYCLES on every accepted byte while in WAIT_*, decrements each clk; reaching 0 aborts as above.
- Not defined: no counter logic; a partial command waits indefinitely until completed, cs_n rises, or reset. TIMEOUT_CYCLES ignored.

## Test plan
- Reset release, no bytes -> digits 0000, colon 11, err_count 0, update never pulses.
- Bytes 0x12, 0x07 -> digit2 = 7, others unchanged, one update pulse one cycle after second byte, busy high between bytes.
- Bytes 0x20, 0x34, 0x12 consecutive cycles -> digits 1234 change together on the third byte only; then 0x40 -> 1235; load FFFF then 0x40 -> 0000.
- Byte 0x20, 0xAB, then cs_n rises -> digits unchanged, err_count = 1, busy low; byte 0x7F -> err_count = 2; 300 illegal bytes with ERR_W = 8 -> err_count = 255.
- Byte 0x31 -> colon = 01; 0x50 -> digits 0000, colon 11.
- Timeout build, TIMEOUT_CYCLES = 16: 0x13 then idle 20 cycles -> abort, err_count = 1; next 0x05 treated as NOP, not data.
